s_spi_byte_engine: RTL

- Clock-domain SPI slave byte engine: oversamples the raw SCLK/MOSI/SS pins on clk and drives MISO.
- Presents received bytes as single-cycle valid pulses and accepts transmit bytes through a one-deep valid/ready holding register.
- Sits directly upstream of the slave top-level message logic: feeds the i_message buffer and consumes o_message bytes.
- SPI mode 0 only (CPOL=0, CPHA=0), MSB first, SS active-low.

---
 rtl/s_spi_byte_engine.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/s_spi_byte_engine.sv
// SPI mode-0 slave byte engine: oversamples SCLK/MOSI/SS on clk, shifts bytes
// in and out MSB first, and holds one transmit byte behind a valid/ready port.
//
// Ports:
//   clk, rst_btn           system clock, synchronous active-low reset
//   SCLK, MOSI, SS         raw SPI pins from the master (asynchronous to clk)
//   MISO, miso_oe          slave-out data and its output enable
//   tx_data/valid/ready    one-deep transmit holding register
//   rx_data, rx_valid      last received byte and its one-cycle update pulse
//   frame_end/error        SS rise pulse, and SS rise with a partial byte
//   tx_underrun            IDLE_BYTE loaded because the holding register was empty
module s_spi_byte_engine #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       SS,
  output logic       MISO,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_end,
  output logic       frame_error,
  output logic       tx_underrun
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  localparam int unsigned    FW    = $clog2(SYNC_STAGES + 2);
  localparam logic [FW-1:0]  FLUSH = FW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic                   sclk_h;
  logic                   ss_h;

  logic sclk_s;
  logic mosi_s;
  logic ss_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;

  state_t        state;
  logic [FW-1:0] flush_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_rx;
  logic [7:0]    shift_tx;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          capture;
  logic          load;

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      sclk_q <= '0;
      mosi_q <= '0;
      ss_q   <= '1;
      sclk_h <= 1'b0;
      ss_h   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], SS};
      sclk_h <= sclk_s;
      ss_h   <= ss_s;
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_h;
  assign sclk_fall = ~sclk_s & sclk_h;
  assign ss_rise   = ss_s & ~ss_h;
  assign ss_fall   = ~ss_s & ss_h;

  assign capture  = tx_valid & ~hold_full;
  assign tx_ready = ~hold_full;
  assign MISO     = miso_oe & shift_tx[7];

  // A load happens at frame start and on the falling SCLK edge that
  // follows each completed byte; SS rise pre-empts the latter.
  always_comb begin
    load = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE):   load = ss_fall;
      (state == ST_ACTIVE): load = ~ss_rise & sclk_fall &
                                   (bit_cnt == 3'd0);
      default:              load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state       <= ST_WAIT;
      flush_cnt   <= FLUSH;
      bit_cnt     <= 3'd0;
      shift_rx    <= 8'h00;
      shift_tx    <= 8'h00;
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      frame_end   <= 1'b0;
      frame_error <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_end   <= 1'b0;
      frame_error <= 1'b0;
      tx_underrun <= 1'b0;

      // Capture only lands when empty, so it never races a draining load.
      if (capture) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end else if (load && hold_full) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shift_tx    <= hold_full ? hold_data : IDLE_BYTE;
        tx_underrun <= ~hold_full;
      end

      case (state)
        // Let the synchronizer drain the reset value before trusting SS,
        // so a frame cut by reset is not mistaken for a new SS fall.
        ST_WAIT: begin
          if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
          end else if (ss_s) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (ss_fall) begin
            bit_cnt <= 3'd0;
            miso_oe <= 1'b1;
            state   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (ss_rise) begin
            frame_end   <= 1'b1;
            frame_error <= (bit_cnt != 3'd0);
            miso_oe     <= 1'b0;
            bit_cnt     <= 3'd0;
            state       <= ST_IDLE;
          end else if (sclk_rise) begin
            shift_rx <= {shift_rx[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data  <= {shift_rx[6:0], mosi_s};
              rx_valid <= 1'b1;
            end
          end else if (sclk_fall && bit_cnt != 3'd0) begin
            shift_tx <= {shift_tx[6:0], 1'b0};
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule
